lif_spike_logger: RTL and testbench
===================================

// Module: lif_spike_logger
//
// PURPOSE
//  Sits directly downstream of the LIF neuron and consumes its one-cycle signal_out spike pulse.
//  - Timestamps each spike with a free-running cycle counter.
//  - Buffers timestamps in a small FIFO that the host/IO side drains with a valid/ready handshake.
//  - Keeps a saturating spike count and a sticky overflow flag for the debug outputs.
//
// PARAMETERS
//  TS_WIDTH   8  width of timestamp counter and of each FIFO entry
//  DEPTH      4  FIFO entries; power of two, >= 2
//  CNT_WIDTH  8  width of saturating total-spike counter
//
// PORTS
//  clk          in   1                    clock
//  rst_n        in   1                    reset, synchronous, active-low
//  en           in   1                    logging enable; gates timestamp advance and spike capture
//  clr          in   1                    synchronous soft clear of all state
//  spike_in     in   1                    spike pulse from neuron signal_out
//  rd_ready     in   1                    consumer accepts rd_data this cycle
//  rd_valid     out  1                    FIFO non-empty; rd_data is valid
//  rd_data      out  TS_WIDTH             oldest buffered timestamp (first-word-fall-through)
//  fifo_level   out  $clog2(DEPTH)+1      number of occupied entries, 0..DEPTH
//  overflow     out  1                    sticky: at least one spike dropped because FIFO full
//  spike_count  out  CNT_WIDTH            total spikes seen since reset/clr, saturating
//
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//  - ts, pointers, level, overflow and spike_count all go to 0.
//  - rd_valid=0; rd_data=0 while empty.
//
//  Timestamp:
//  - ts increments by 1 at every posedge with en=1 and clr=0.
//  - Wraps 2^TS_WIDTH-1 -> 0 with no flag.
//  - Holds while en=0.
//
//  Capture:
//  - spike_in=1 sampled at a posedge with en=1 is one spike.
//  - The captured value is ts before that edge's increment.
//  - Each high cycle counts as a separate spike; there is no edge detection.
//  - With en=0, spikes are ignored entirely: no push, no count.
//
//  Push/pop (all at the same posedge):
//  - push_req = capture. pop = rd_valid & rd_ready.
//  - Pop when empty cannot occur, since rd_valid=0.
//  - Not full: push writes the tail entry.
//  - Full and pop: push and pop both succeed; level stays DEPTH; no overflow.
//  - Full and no pop: spike is dropped; overflow <= 1 (sticky); level unchanged.
//  - Push and pop with 0 < level < DEPTH: level unchanged.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally.
//
//  Output timing:
//  - rd_valid = (level != 0).
//  - rd_data = mem[rd_ptr], combinational from registered state.
//  - Latency: spike at edge N -> rd_valid=1 and data visible after edge N (no extra stage).
//
//  Handshake:
//  - Once rd_valid=1, rd_data stays stable until popped. Only a clr or reset may remove it.
//  - rd_ready does not have to wait for rd_valid.
//
//  spike_count:
//  - Increments on every capture, including dropped spikes.
//  - Saturates at 2^CNT_WIDTH-1.
//
//  clr=1:
//  - Next state equals the reset state.
//  - Overrides a same-cycle capture or pop; that spike is neither stored nor counted.
//
//  Reset mid-operation: all buffered entries are discarded and there is no partial state.
//
// STRUCTURE
//  - Shared header lif_defs.vh: default TS_WIDTH/CNT_WIDTH and the LIF_SPIKE_FIFO_DEPTH constant, shared with the neuron top.
//  - Sub-module lif_spike_fifo: sync FWFT FIFO with ports push, wdata, pop, rdata, level, full, empty.
//  - Top level holds the ts counter, capture/overflow logic and spike_count.
//
// TESTING
//  1. Reset, en=1, spike_in pulses at ts=3,7,12 with rd_ready=0 -> level=3; then rd_ready=1 -> rd_data 3,7,12 popped in order; rd_valid drops after the 3rd pop.
//  2. DEPTH=4, rd_ready=0, 6 spikes -> level=4, first 4 ts kept, overflow=1, spike_count=6.
//  3. FIFO full, spike_in=1 and rd_ready=1 together -> oldest popped, new ts stored, level=4, overflow stays 0.
//  4. en=1 for 260 cycles, TS_WIDTH=8 -> ts wraps; a spike 4 cycles after the wrap logs 4; a spike with en=0 is not logged or counted.
//  5. Full FIFO with overflow=1, clr=1 together with spike_in=1 -> next cycle level=0, overflow=0, spike_count=0, rd_valid=0, ts=0.
//  6. spike_in held high 300 cycles, rd_ready=1, CNT_WIDTH=8 -> spike_count saturates at 255; consecutive timestamps are logged with no drops.

Source files
------------

// File: rtl/lif_spike_logger_pkg.sv
// -----------------------------------------------------------------------------
// lif_spike_logger_pkg
// Defaults shared by the spike logger and the LIF neuron top:
//   LIF_TS_WIDTH          default timestamp / FIFO entry width
//   LIF_CNT_WIDTH         default saturating spike counter width
//   LIF_SPIKE_FIFO_DEPTH  number of buffered timestamps
// Also defines the FIFO operation encoding and a saturating-increment helper.
// -----------------------------------------------------------------------------
package lif_spike_logger_pkg;

  localparam int LIF_TS_WIDTH         = 8;
  localparam int LIF_CNT_WIDTH        = 8;
  localparam int LIF_SPIKE_FIFO_DEPTH = 4;

  // {push, pop} as seen by the FIFO after qualification
  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_POP  = 2'b01,
    FIFO_OP_PUSH = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

  // Returns 1 when a counter value is all ones (its saturation point).
  function automatic logic is_all_ones(input logic [31:0] value, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value & mask) == mask;
  endfunction

endpackage

// File: rtl/lif_spike_logger_fifo.sv
// -----------------------------------------------------------------------------
// lif_spike_logger_fifo
// Synchronous first-word-fall-through FIFO holding spike timestamps.
// Ports:
//   clk, rst_n (sync, active-low), clr (sync soft clear)
//   push / wdata : write request and data
//   pop          : consumer takes rdata this cycle
//   rdata        : oldest entry, 0 while empty
//   level        : occupied entries 0..DEPTH
//   full, empty  : status flags
// A push while full is only honoured together with a pop; a pop while empty is
// ignored, so the caller cannot corrupt the pointers.
// -----------------------------------------------------------------------------
module lif_spike_logger_fifo
  import lif_spike_logger_pkg::*;
#(
  parameter int W     = LIF_TS_WIDTH,
  parameter int DEPTH = LIF_SPIKE_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic     w_push_ok;
  logic     w_pop_ok;
  fifo_op_e w_op;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);

  assign w_pop_ok  = pop & ~empty & rst_n & ~clr;
  assign w_push_ok = push & (~full | w_pop_ok) & rst_n & ~clr;
  assign w_op      = fifo_op_e'({w_push_ok, w_pop_ok});

  // Storage carries no reset; emptiness is tracked by r_level alone.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      case (w_op)
        FIFO_OP_PUSH: begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_level  <= r_level + LW'(1);
        end
        FIFO_OP_POP: begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_level  <= r_level - LW'(1);
        end
        FIFO_OP_BOTH: begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rdata = empty ? '0 : r_mem[r_rd_ptr];
  assign level = r_level;

endmodule

// File: rtl/lif_spike_logger.sv
// -----------------------------------------------------------------------------
// lif_spike_logger
// Timestamps spike pulses from the LIF neuron and buffers them for the host.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              logging enable (gates timestamp advance and capture)
//   clr             synchronous soft clear of all state
//   spike_in        one-cycle spike pulse (every high cycle is a spike)
//   rd_ready        consumer accepts rd_data this cycle
//   rd_valid        FIFO non-empty
//   rd_data         oldest buffered timestamp (first-word-fall-through)
//   fifo_level      occupied entries, 0..DEPTH
//   overflow        sticky: a spike was dropped because the FIFO was full
//   spike_count     saturating count of captured spikes (dropped ones too)
// -----------------------------------------------------------------------------
module lif_spike_logger
  import lif_spike_logger_pkg::*;
#(
  parameter int TS_WIDTH  = LIF_TS_WIDTH,
  parameter int DEPTH     = LIF_SPIKE_FIFO_DEPTH,
  parameter int CNT_WIDTH = LIF_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       spike_in,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [TS_WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [CNT_WIDTH-1:0]       spike_count
);

  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_spike_count;

  logic w_capture;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_empty;

  // clr wins over a same-cycle spike or pop
  assign w_capture = en & spike_in & ~clr;
  assign w_pop     = ~w_empty & rd_ready & ~clr;
  // A full FIFO still accepts the spike when the head leaves in the same cycle
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  lif_spike_logger_fifo #(
    .W     (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (w_push),
    .wdata (r_ts),
    .pop   (w_pop),
    .rdata (rd_data),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_ts          <= '0;
      r_overflow    <= 1'b0;
      r_spike_count <= '0;
    end else begin
      if (en) begin
        r_ts <= r_ts + TS_WIDTH'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_capture && !is_all_ones(32'(r_spike_count), CNT_WIDTH)) begin
        r_spike_count <= r_spike_count + CNT_WIDTH'(1);
      end
    end
  end

  assign rd_valid    = ~w_empty;
  assign overflow    = r_overflow;
  assign spike_count = r_spike_count;

endmodule

// File: tb/tb_lif_spike_logger.sv
// -----------------------------------------------------------------------------
// tb_lif_spike_logger
// Directed scenarios followed by a randomized run, every cycle compared against
// a queue-based reference model of the logger.
// -----------------------------------------------------------------------------
module tb_lif_spike_logger;

  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic                   clr = 1'b0;
  logic                   spike_in = 1'b0;
  logic                   rd_ready = 1'b0;
  logic                   rd_valid;
  logic [TS_W-1:0]        rd_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic [CNT_W-1:0]       spike_count;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int q[$];
  int m_ts  = 0;
  bit m_ovf = 1'b0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  lif_spike_logger #(
    .TS_WIDTH  (TS_W),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .spike_in    (spike_in),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .spike_count (spike_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model one clock edge from the inputs currently applied.
  task automatic model_step();
    bit take;
    if (!rst_n || clr) begin
      q.delete();
      m_ts  = 0;
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      take = (q.size() > 0) && rd_ready;
      if (take) void'(q.pop_front());
      if (en && spike_in) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (q.size() < DEPTH) q.push_back(m_ts);
        else m_ovf = 1'b1;
      end
      if (en) m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  task automatic check_model();
    check("rd_valid",    32'(rd_valid),    32'(q.size() > 0));
    check("rd_data",     32'(rd_data),     (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check("fifo_level",  32'(fifo_level),  32'(q.size()));
    check("overflow",    32'(overflow),    32'(m_ovf));
    check("spike_count", 32'(spike_count), 32'(m_cnt));
  endtask

  task automatic cycle(input bit e, input bit s, input bit r, input bit c, input bit rn);
    @(negedge clk);
    en = e; spike_in = s; rd_ready = r; clr = c; rst_n = rn;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    // Reset state
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_level", 32'(fifo_level), 32'd0);
    $display("reset: level=%0d valid=%0d count=%0d", fifo_level, rd_valid, spike_count);

    // 1: spikes at ts 3,7,12 then drain in order
    for (int k = 0; k <= 12; k++) cycle(1, (k == 3 || k == 7 || k == 12), 0, 0, 1);
    check("t1_level", 32'(fifo_level), 32'd3);
    check("t1_head", 32'(rd_data), 32'd3);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 1, 0, 1);
      $display("t1 pop %0d: level=%0d data=%0d", k, fifo_level, rd_data);
    end
    check("t1_drained", 32'(rd_valid), 32'd0);

    // 2: six spikes into a 4-deep FIFO with no reader
    cycle(1, 0, 0, 1, 1);
    for (int k = 0; k < 6; k++) cycle(1, 1, 0, 0, 1);
    check("t2_level", 32'(fifo_level), 32'd4);
    check("t2_head", 32'(rd_data), 32'd0);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_count", 32'(spike_count), 32'd6);
    $display("t2: level=%0d ovf=%0d count=%0d", fifo_level, overflow, spike_count);

    // 3: full FIFO, push and pop together
    cycle(1, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 0, 1);
    check("t3_level", 32'(fifo_level), 32'd4);
    check("t3_head", 32'(rd_data), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd0);
    $display("t3: level=%0d head=%0d ovf=%0d", fifo_level, rd_data, overflow);

    // 4: timestamp wrap, then a spike with en=0
    cycle(1, 0, 0, 1, 1);
    for (int k = 0; k < 260; k++) cycle(1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    check("t4_wrap_ts", 32'(rd_data), 32'd4);
    cycle(0, 1, 0, 0, 1);
    check("t4_en0_count", 32'(spike_count), 32'd1);
    check("t4_en0_level", 32'(fifo_level), 32'd1);
    $display("t4: head=%0d level=%0d count=%0d", rd_data, fifo_level, spike_count);

    // 5: clr together with a spike on a full, overflowed FIFO
    cycle(1, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 1, 1);
    check("t5_level", 32'(fifo_level), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_count", 32'(spike_count), 32'd0);
    check("t5_valid", 32'(rd_valid), 32'd0);
    cycle(1, 1, 0, 0, 1);
    check("t5_ts_zero", 32'(rd_data), 32'd0);
    $display("t5: level=%0d head=%0d", fifo_level, rd_data);

    // 6: continuous spikes with an always-ready reader
    cycle(1, 0, 0, 1, 1);
    for (int k = 0; k < 300; k++) cycle(1, 1, 1, 0, 1);
    check("t6_sat", 32'(spike_count), 32'd255);
    check("t6_no_drop", 32'(overflow), 32'd0);
    $display("t6: count=%0d ovf=%0d head=%0d", spike_count, overflow, rd_data);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cycle(($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) != 0));
    end
    $display("random: level=%0d ovf=%0d count=%0d", fifo_level, overflow, spike_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
